psum_accumulator: RTL and testbench

- Streaming signed accumulator directly downstream of the carry-lookahead adder stage in the partial-sum path.
- Takes one signed DATA_WIDTH partial sum per cycle over a valid/ready handshake and adds it into an ACC_WIDTH register through one adder instance.
- Emits one accumulated result per group, delimited by in_last, with a term count and an overflow flag, to the output-buffer stage.

---
 rtl/psum_accumulator_pkg.sv | 19 +
 rtl/psum_accumulator_cla.sv | 45 ++++
 rtl/psum_accumulator.sv | 106 ++++++++++
 tb/tb_psum_accumulator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/psum_accumulator_pkg.sv
// Shared definitions for the partial-sum accumulator: FSM state encoding and
// signed saturation limits derived from the accumulator width (up to 64 bits).
package psum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } stateT;

    function automatic logic [63:0] accMax(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] accMin(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/psum_accumulator_cla.sv
// Carry-lookahead adder: carries are resolved in 4-bit lookahead groups,
// with the group carry rippling from one group into the next.
module CLA #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;
    logic             term;
    logic             chain;

    assign gen  = A & B;
    assign prop = A ^ B;

    // Each carry is the OR of every generate inside its group that can
    // propagate up to it, plus the group's incoming carry.
    always_comb begin
        carry    = '0;
        carry[0] = Ci;
        term     = 1'b0;
        chain    = 1'b0;
        for (int base = 0; base < WIDTH; base += 4) begin
            for (int i = base; (i < base + 4) && (i < WIDTH); i++) begin
                term  = gen[i];
                chain = prop[i];
                for (int j = i - 1; j >= base; j--) begin
                    term  = term | (chain & gen[j]);
                    chain = chain & prop[j];
                end
                carry[i + 1] = term | (chain & carry[base]);
            end
        end
    end

    assign S  = prop ^ carry[WIDTH-1:0];
    assign Co = carry[WIDTH];

endmodule

// File: rtl/psum_accumulator.sv
// Streaming signed accumulator: sums one partial sum per accepted beat and
// presents one result per in_last-delimited group with a term count and sticky overflow.
module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_ovf
);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(accMax(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(accMin(ACC_WIDTH));

    stateT                 state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;

    logic [ACC_WIDTH-1:0]  operand;
    logic [ACC_WIDTH-1:0]  sum;
    logic                  sumCarry;
    logic                  ovfNow;
    logic [ACC_WIDTH-1:0]  addResult;
    logic [CNT_WIDTH-1:0]  cntNext;

    assign operand = ACC_WIDTH'($signed(in_data));

    CLA #(
        .WIDTH(ACC_WIDTH)
    ) u_cla (
        .A (acc_q),
        .B (operand),
        .Ci(1'b0),
        .S (sum),
        .Co(sumCarry)
    );

    // Carry-out tells the clamp direction: two negatives overflowing always carry out.
    assign ovfNow    = (acc_q[ACC_WIDTH-1] == operand[ACC_WIDTH-1]) &&
                       (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    assign addResult = (ovfNow && (SATURATE != 0)) ? (sumCarry ? ACC_MIN : ACC_MAX) : sum;
    assign cntNext   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = addResult;
                    cnt_d   = cntNext;
                    ovf_d   = ovf_q | ovfNow;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Group registers double as the result registers; they are frozen in HOLD.
    assign out_data  = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: one default instance plus saturating and
// wrapping 16-bit-accumulator instances, all driven by the same beat stream.
module tb_psum_accumulator;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [15:0] inData;
    logic        inLast;
    logic        outReady;

    logic        inReady32, outValid32, outOvf32;
    logic [31:0] outData32;
    logic [7:0]  outCount32;

    logic        inReadySat, outValidSat, outOvfSat;
    logic [15:0] outDataSat;
    logic [7:0]  outCountSat;

    logic        inReadyWrap, outValidWrap, outOvfWrap;
    logic [15:0] outDataWrap;
    logic [7:0]  outCountWrap;

    int checkCount;
    int errorCount;

    psum_accumulator #(
        .DATA_WIDTH(16), .ACC_WIDTH(32), .CNT_WIDTH(8), .SATURATE(1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady32), .in_data(inData), .in_last(inLast),
        .out_valid(outValid32), .out_ready(outReady), .out_data(outData32),
        .out_count(outCount32), .out_ovf(outOvf32)
    );

    psum_accumulator #(
        .DATA_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8), .SATURATE(1)
    ) dutSat (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReadySat), .in_data(inData), .in_last(inLast),
        .out_valid(outValidSat), .out_ready(outReady), .out_data(outDataSat),
        .out_count(outCountSat), .out_ovf(outOvfSat)
    );

    psum_accumulator #(
        .DATA_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(8), .SATURATE(0)
    ) dutWrap (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReadyWrap), .in_data(inData), .in_last(inLast),
        .out_valid(outValidWrap), .out_ready(outReady), .out_data(outDataWrap),
        .out_count(outCountWrap), .out_ovf(outOvfWrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; presents one beat, waits (bounded) for acceptance,
    // and returns at the negedge following the accepting edge.
    task automatic applyStimulus(input logic [15:0] d, input logic last);
        int waitCycles;
        waitCycles = 0;
        inValid = 1'b1;
        inData  = d;
        inLast  = last;
        while (!inReady32 && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!inReady32) checkOutput("beatAcceptTimeout", 64'(inReady32), 64'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkGroup(input string tag, input logic [63:0] exp32,
                              input logic [63:0] expSat, input logic [63:0] expWrap,
                              input logic [63:0] expCount, input logic expOvf32,
                              input logic expOvf16);
        checkOutput($sformatf("%s_valid32", tag), 64'(outValid32), 64'd1);
        checkOutput($sformatf("%s_validSat", tag), 64'(outValidSat), 64'd1);
        checkOutput($sformatf("%s_validWrap", tag), 64'(outValidWrap), 64'd1);
        checkOutput($sformatf("%s_data32", tag), 64'(outData32), exp32);
        checkOutput($sformatf("%s_dataSat", tag), 64'(outDataSat), expSat);
        checkOutput($sformatf("%s_dataWrap", tag), 64'(outDataWrap), expWrap);
        checkOutput($sformatf("%s_count32", tag), 64'(outCount32), expCount);
        checkOutput($sformatf("%s_countSat", tag), 64'(outCountSat), expCount);
        checkOutput($sformatf("%s_countWrap", tag), 64'(outCountWrap), expCount);
        checkOutput($sformatf("%s_ovf32", tag), 64'(outOvf32), 64'(expOvf32));
        checkOutput($sformatf("%s_ovfSat", tag), 64'(outOvfSat), 64'(expOvf16));
        checkOutput($sformatf("%s_ovfWrap", tag), 64'(outOvfWrap), 64'(expOvf16));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput($sformatf("%s_valid", tag), 64'(outValid32), 64'd0);
        checkOutput($sformatf("%s_ready32", tag), 64'(inReady32), 64'd1);
        checkOutput($sformatf("%s_readySat", tag), 64'(inReadySat), 64'd1);
        checkOutput($sformatf("%s_readyWrap", tag), 64'(inReadyWrap), 64'd1);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst      = 1'b1;
        inValid  = 1'b0;
        inData   = '0;
        inLast   = 1'b0;
        outReady = 1'b1;

        // Reset values while reset is held
        @(negedge clk);
        @(negedge clk);
        checkIdle("reset");
        checkOutput("reset_data", 64'(outData32), 64'd0);
        checkOutput("reset_count", 64'(outCount32), 64'd0);
        checkOutput("reset_ovf", 64'(outOvf32), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic group 3, -5, 10
        applyStimulus(16'd3, 1'b0);
        applyStimulus(16'hFFFB, 1'b0);
        checkOutput("basic_validBeforeLast", 64'(outValid32), 64'd0);
        applyStimulus(16'd10, 1'b1);
        inValid = 1'b0;
        checkGroup("basic", 64'd8, 64'd8, 64'd8, 64'd3, 1'b0, 1'b0);
        checkOutput("basic_readyInHold", 64'(inReady32), 64'd0);
        @(negedge clk);
        checkIdle("basicDone");

        // Single-beat group at the most negative input
        applyStimulus(16'h8000, 1'b1);
        inValid = 1'b0;
        checkGroup("single", 64'hFFFF8000, 64'h8000, 64'h8000, 64'd1, 1'b0, 1'b0);
        checkOutput("single_readyLow", 64'(inReady32), 64'd0);
        @(negedge clk);
        checkIdle("singleDone");

        // Positive overflow: 16-bit clamps then continues, 16-bit wraps
        applyStimulus(16'd30000, 1'b0);
        applyStimulus(16'd30000, 1'b0);
        applyStimulus(16'hFFFF, 1'b1);
        inValid = 1'b0;
        checkGroup("ovf", 64'd59999, 64'd32766, 64'hEA5F, 64'd3, 1'b0, 1'b1);
        @(negedge clk);
        checkIdle("ovfDone");

        // Back-pressure on the result while the next beat waits
        outReady = 1'b0;
        applyStimulus(16'd1, 1'b0);
        applyStimulus(16'd2, 1'b1);
        inValid = 1'b1;
        inData  = 16'd100;
        inLast  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkGroup($sformatf("hold%0d", i), 64'd3, 64'd3, 64'd3, 64'd2, 1'b0, 1'b0);
            checkOutput($sformatf("hold%0d_ready", i), 64'(inReady32), 64'd0);
            @(negedge clk);
        end
        outReady = 1'b1;
        @(negedge clk);
        checkIdle("released");
        checkOutput("released_count", 64'(outCount32), 64'd0);
        applyStimulus(16'd100, 1'b0);
        applyStimulus(16'd5, 1'b1);
        inValid = 1'b0;
        checkGroup("afterHold", 64'd105, 64'd105, 64'd105, 64'd2, 1'b0, 1'b0);
        @(negedge clk);

        // Counter saturation over a 300-beat group
        for (int i = 0; i < 300; i++) begin
            applyStimulus(16'd1, (i == 299));
        end
        inValid = 1'b0;
        checkGroup("count", 64'd300, 64'd300, 64'd300, 64'd255, 1'b0, 1'b0);
        @(negedge clk);

        // Reset in the middle of a group discards the partial sum
        applyStimulus(16'd4, 1'b0);
        applyStimulus(16'd5, 1'b0);
        inValid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkIdle("midReset");
        checkOutput("midReset_data", 64'(outData32), 64'd0);
        checkOutput("midReset_count", 64'(outCount32), 64'd0);
        checkOutput("midReset_ovf", 64'(outOvf32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(16'd7, 1'b1);
        inValid = 1'b0;
        checkGroup("postReset", 64'd7, 64'd7, 64'd7, 64'd1, 1'b0, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
